fetch_unit: RTL

- Instruction fetch front end for the RV32I datapath. It drives the instruction-memory request interface and buffers returned words in a small prefetch FIFO.
- It presents {inst, pc} to the control-logic/decode stage with a valid/ready handshake.
- It consumes the decoder's PC-select decision and the ALU branch/jump target to redirect fetch, discarding wrong-path words.

---
 rtl/fetch_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end with an instruction-memory request
// port, an in-order PC tag queue and a FIFO_DEPTH-entry prefetch FIFO.
// Ports: clk_i/rst_i (sync, active-high); imem_req_o/imem_addr_o/
// imem_gnt_i/imem_rvalid_i/imem_rdata_i to memory; inst_o/pc_o/
// inst_valid_o/inst_ready_i to decode; PCSel_i/alu_target_i redirect;
// misalign_o trap flag.
// Optional: FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        PCSel_i,
  input  logic [31:0] alu_target_i,
  output logic        misalign_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t ONE  = ptr_t'(1);
  localparam ptr_t FULL = ptr_t'(FIFO_DEPTH);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_HALT = 2'd2;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_disc_q, pend_disc_d;
  ptr_t        disc_q, disc_d;
  ptr_t        f_wp_q, f_wp_d;
  ptr_t        f_rp_q, f_rp_d;
  ptr_t        t_wp_q, t_wp_d;
  ptr_t        t_rp_q, t_rp_d;

  logic [31:0] inst_mem_q [FIFO_DEPTH];
  logic [31:0] pc_mem_q   [FIFO_DEPTH];
  logic [31:0] tag_mem_q  [FIFO_DEPTH];

  ptr_t        occ;
  ptr_t        outs;
  logic [PW:0] busy;
  logic        run;
  logic        pop;
  logic        redir;
  logic        gnt;
  logic        drop;
  logic        push;

  assign occ   = f_wp_q - f_rp_q;
  assign outs  = t_wp_q - t_rp_q;
  assign busy  = {1'b0, occ} + {1'b0, outs};
  assign run   = (state_q == S_RUN);

  assign inst_valid_o = (occ != '0);
  assign inst_o       = inst_mem_q[f_rp_q[AW-1:0]];
  assign pc_o         = pc_mem_q[f_rp_q[AW-1:0]];

  assign pop   = inst_valid_o & inst_ready_i;
  assign redir = pop & PCSel_i;

  // A request already on the bus stays there, even across a redirect.
  assign imem_req_o  = pend_q |
                       (run & (busy < {1'b0, FULL}) & ~redir);
  assign imem_addr_o = pend_q ? pend_pc_q : fetch_pc_q;
  assign gnt         = imem_req_o & imem_gnt_i;

  assign drop = (disc_q != '0);
  assign push = imem_rvalid_i & ~drop & ~redir & run;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic bad_tgt;
  assign bad_tgt    = (alu_target_i[1:0] != 2'b00);
  assign misalign_o = misalign_q;
`else
  logic unused_tgt;
  assign unused_tgt = ^alu_target_i[1:0];
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    pend_disc_d = pend_disc_q;
    disc_d      = disc_q;
    f_wp_d      = f_wp_q;
    f_rp_d      = f_rp_q;
    t_wp_d      = t_wp_q;
    t_rp_d      = t_rp_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif

    if (state_q == S_BOOT) state_d = S_RUN;

    if (gnt)           t_wp_d = t_wp_q + ONE;
    if (imem_rvalid_i) t_rp_d = t_rp_q + ONE;
    if (imem_rvalid_i && drop) disc_d = disc_q - ONE;

    // fetch_pc runs one word ahead of a stalled request.
    if (pend_q) begin
      if (imem_gnt_i) begin
        pend_d      = 1'b0;
        pend_disc_d = 1'b0;
        if (pend_disc_q) disc_d = disc_d + ONE;
      end
    end else if (imem_req_o) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      if (!imem_gnt_i) begin
        pend_d    = 1'b1;
        pend_pc_d = fetch_pc_q;
      end
    end

    if (push) f_wp_d = f_wp_q + ONE;
    if (pop)  f_rp_d = f_rp_q + ONE;

    // Every word still owed by memory is wrong-path after a redirect.
    if (redir) begin
      f_rp_d     = f_wp_q;
      fetch_pc_d = {alu_target_i[31:2], 2'b00};
      disc_d     = t_wp_d - t_rp_d;
      if (pend_q && !imem_gnt_i) pend_disc_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bad_tgt) begin
        state_d    = S_HALT;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= RESET_PC;
      pend_disc_q <= 1'b0;
      disc_q      <= '0;
      f_wp_q      <= '0;
      f_rp_q      <= '0;
      t_wp_q      <= '0;
      t_rp_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= RESET_PC;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      pend_disc_q <= pend_disc_d;
      disc_q      <= disc_d;
      f_wp_q      <= f_wp_d;
      f_rp_q      <= f_rp_d;
      t_wp_q      <= t_wp_d;
      t_rp_q      <= t_rp_d;
      if (push) begin
        inst_mem_q[f_wp_q[AW-1:0]] <= imem_rdata_i;
        pc_mem_q[f_wp_q[AW-1:0]]   <= tag_mem_q[t_rp_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) tag_mem_q[t_wp_q[AW-1:0]] <= imem_addr_o;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && occ == FULL));

endmodule
